// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, flush and redirect PC,
// plus the latency counter for multi-cycle ex operations.
module pipe_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              mc_start,
  input  logic              excp_i,
  input  logic [ADDR_W-1:0] excp_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_finish_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MC    = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [5:0] STALL_MC = 6'b000111;
  localparam logic [5:0] STALL_LU = 6'b000011;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [5:0]        stall_d;
  logic              fin_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    stall_d = '0;
    fin_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (excp_i) begin
          pc_d    = excp_pc_i;
          state_d = FLUSH;
        end else if (mc_start) begin
          stall_d = STALL_MC;
          cnt_d   = CNT_INIT;
          state_d = MC;
        end else if (stallreq_id) begin
          stall_d = STALL_LU;
        end
      end
      MC: begin
        // an exception aborts the op: no finish pulse
        if (excp_i) begin
          pc_d    = excp_pc_i;
          cnt_d   = '0;
          state_d = FLUSH;
        end else if (cnt_q != '0) begin
          stall_d = STALL_MC;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          fin_d   = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // gate the input-driven outputs so they stay quiet during reset
  assign stall_o     = rst ? stall_d : 6'b0;
  assign mc_finish_o = rst & fin_d;
  assign flush_o     = (state_q == FLUSH);
  assign mc_busy_o   = (state_q == MC);
  assign state_o     = state_q;
  assign new_pc_o    = pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int MC_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        mc_start = 1'b0;
  logic        excp_i = 1'b0;
  logic [31:0] excp_pc_i = '0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_finish_o;
  logic [1:0]  state_o;

  pipe_ctrl #(.MC_LAT(MC_LAT), .CNT_W(6), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .mc_start    (mc_start),
    .excp_i      (excp_i),
    .excp_pc_i   (excp_pc_i),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .new_pc_o    (new_pc_o),
    .mc_busy_o   (mc_busy_o),
    .mc_finish_o (mc_finish_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: cycles left until the op's finish cycle, pending flush, PC
  int          m_left = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc = '0;
  int          n_left;
  bit          n_flush;
  logic [31:0] n_pc;
  logic [42:0] exp_v;

  function automatic logic [42:0] obs();
    return {stall_o, flush_o, new_pc_o, mc_busy_o, mc_finish_o, state_o};
  endfunction

  task automatic model_eval();
    logic [5:0] st = '0;
    logic fin = 1'b0;
    logic busy = (m_left > 0);
    logic [1:0] sv = m_flush ? 2'd2 : (busy ? 2'd1 : 2'd0);
    n_left  = m_left;
    n_flush = 1'b0;
    n_pc    = m_pc;
    if (!rst) begin
      exp_v  = '0;
      n_left = 0;
      n_pc   = '0;
      return;
    end
    if (m_flush) begin
      n_left = 0;
    end else if (busy) begin
      if (excp_i) begin
        n_pc = excp_pc_i; n_flush = 1'b1; n_left = 0;
      end else if (m_left == 1) begin
        fin = 1'b1; n_left = 0;
      end else begin
        st = 6'd7; n_left = m_left - 1;
      end
    end else if (excp_i) begin
      n_pc = excp_pc_i; n_flush = 1'b1;
    end else if (mc_start) begin
      st = 6'd7; n_left = MC_LAT - 1;
    end else if (stallreq_id) begin
      st = 6'd3;
    end
    exp_v = {st, m_flush, m_pc, busy, fin, sv};
  endtask

  task automatic commit();
    m_left  = n_left;
    m_flush = n_flush;
    m_pc    = n_pc;
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drive(input bit sr, input bit mc, input bit ex,
                       input logic [31:0] pc);
    stallreq_id = sr;
    mc_start    = mc;
    excp_i      = ex;
    excp_pc_i   = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== 43'd0) begin
        errors++;
        $display("FAIL reset cyc%0d got=%h want=0", i, obs());
      end
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    checks++;
    if (obs() !== exp_v || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs(), exp_v);
    end
    tick();
  endtask

  task automatic test_mc();
    for (int i = 0; i < 6; i++) begin
      drive(0, i == 0, 0, 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL mc cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      if (i == 3) begin
        checks++;
        if (mc_finish_o !== 1'b1 || stall_o !== 6'd0) begin
          errors++;
          $display("FAIL mc_finish got fin=%b stall=%b want fin=1 stall=0",
                   mc_finish_o, stall_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 0, 0, 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL load_use cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 1, 1, 32'hBFC0_0380);
      else drive(0, 0, 0, 32'h1234_5678);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL priority cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      if (i == 1) begin
        checks++;
        if (flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0380) begin
          errors++;
          $display("FAIL priority_pc got flush=%b pc=%h want 1 bfc00380",
                   flush_o, new_pc_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      drive(0, i == 0 || i == 2, i == 1, 32'h0000_0180);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL abort cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mc();
    drive(1, 1, 0, 0);
    @(negedge clk);
    model_eval();
    tick();
    drive(1, 1, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_eval();
    commit();
    checks++;
    if (obs() !== 43'd0) begin
      errors++;
      $display("FAIL async_rst got=%h want=0", obs());
    end
    tick();
    model_eval();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, i == 0, 0, 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL rst_mc cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
            $urandom_range(0, 19) < 2, $urandom);
      @(negedge clk);
      model_eval();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL random cyc%0d got=%h want=%h", i, obs(), exp_v);
      end
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mc();
    test_load_use();
    test_priority();
    test_abort();
    test_reset_mid_mc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
